// File: rtl/bus_arb4_pkg.sv
// Shared types, widths and the round-robin pick for the 4-way bus arbiter.
package bus_arb4_pkg;

    localparam int unsigned N_REQ         = 4;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned SEL_W         = 2;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request bit scanning ptr, ptr+1, ... modulo 4.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                  input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/bus_arb4_mux16_4.sv
// 4:1 mux of 16-bit words; the arbiter's shared datapath.
module mux16_4
    import bus_arb4_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        unique case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/bus_arb4.sv
// Round-robin arbiter for four requesters sharing a 16-bit mux, with a
// valid/ready consumer port and a per-grant burst limit.
module bus_arb4
    import bus_arb4_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic              ready,
    output logic [N_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out,
    output logic              valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [SEL_W-1:0] sel_n;
    logic [SEL_W-1:0] winner;
    logic             xfer;
    logic             others;

    // Owner data is valid only while the owner still requests.
    assign valid  = (state == GRANT) && req[sel];
    assign xfer   = valid && ready;
    assign others = |(req & ~gnt);
    assign winner = rr_pick(req, ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                if (|req) begin
                    gnt_n   = N_REQ'(1) << winner;
                    sel_n   = winner;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            default: begin
                // Owner dropping its request wins over the burst limit.
                if (!req[sel] || (xfer && (cnt == CNT_LAST) && others)) begin
                    ptr_n   = sel + SEL_W'(1);
                    gnt_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (xfer) begin
                    cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                end
            end
        endcase
    end

    mux16_4 u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel),
        .out (out)
    );

endmodule

// File: doc/bus_arb4.md
# bus_arb4

Round-robin arbiter and sequencer for a shared 4-input, 16-bit selection datapath. It grants exactly one of four requesters ownership of the shared bus and drives the data-select of the 4:1 16-bit mux. It presents the selected word to a single downstream consumer with a valid/ready handshake. A burst limit ensures no requester holds the bus indefinitely while others wait.

## Interface
Parameters:
- MAX_BURST, default 4: transfers a requester may complete per grant while another request is pending; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester request; bit i belongs to requester i; held high while the requester has data.
- in0..in3  input  16 each  requester data words.
- ready  input  1  consumer accepts the current word this cycle.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- sel  output  2  registered index of the current owner; drives the mux select.
- out  output  16  in[sel], taken combinationally through the mux.
- valid  output  1  out carries owner data this cycle.

## Operation
- Two states, IDLE and GRANT, with a 2-bit round-robin pointer ptr and a 4-bit burst counter cnt.
- IDLE:
  - If req is nonzero, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - Register gnt = onehot(winner), sel = winner, cnt = 0, then go to GRANT.
  - If req is zero, stay in IDLE with gnt = 0.
- GRANT:
  - valid = req[sel]; this is combinational, so an owner dropping req deasserts valid in the same cycle.
  - A transfer occurs on any cycle with valid && ready.
  - Each transfer increments cnt.
- Release at the clock edge when either condition holds:
  - (a) req[sel] == 0, or
  - (b) a transfer with cnt == MAX_BURST-1 while any other req bit is set.
- On release:
  - ptr = sel+1 (2-bit wrap, so 3 wraps to 0).
  - gnt = 0, cnt = 0, state = IDLE.
- Burst limit with no competitor: if cnt reaches MAX_BURST-1 on a transfer and no other req is set, cnt wraps to 0 and the grant is kept.
- ready while valid is low has no effect. valid never asserts in IDLE.
- A new req from a non-owner during GRANT has no effect on gnt until release.
- Reset values:
  - state IDLE, ptr 0, cnt 0, gnt 4'b0000, sel 2'b00, valid 0.
  - out = in0, because sel = 0.

## Timing
- Grant latency: req rises in cycle N while IDLE -> gnt and sel update at the edge ending N -> valid can be high in N+1.
- Release bubble: the release edge ends cycle M -> cycle M+1 is IDLE (valid 0, arbitration happens) -> the next owner is valid in M+2.
- Sustained throughput for one owner with ready held high: one word per cycle.
- Simultaneous events at the same edge:
  - Release condition (a) takes precedence over (b).
  - rst takes precedence over everything: a reset mid-burst clears gnt, valid and cnt at the next edge, and ptr returns to 0.
- The out path is combinational from sel and in0..in3 only; no input-to-gnt combinational path exists.

## Structure
- Shared constants include file holds:
  - state encodings IDLE = 1'b0, GRANT = 1'b1;
  - default MAX_BURST.
- The data path is one instance of the team's mux16_4 sub-module, with .sel driven by the registered sel and .out driving out.
- Flops are built from the team's standard dff cells; next-state logic is in one combinational block.
- Round-robin priority pick is a small function or case on ptr, with no separate module.

## Test plan
- Reset: hold rst for 2 cycles with req = 4'b1111 -> gnt = 0, valid = 0, sel = 0 and out = in0 during reset; after rst drops, gnt = 4'b0001 one cycle later.
- Single requester: req = 4'b0100, in2 = 16'hBEEF, ready = 1 -> gnt = 4'b0100 after 1 cycle, then valid = 1 and out = 16'hBEEF every cycle. No release occurs past MAX_BURST transfers.
- Burst limit fairness: req = 4'b0011, ready = 1, MAX_BURST = 4 -> requester 0 gets 4 transfers, then 1 idle cycle, then requester 1 gets 4 transfers, alternating indefinitely.
- Backpressure: owner 3 with ready low for 5 cycles -> valid stays 1, out stays stable and cnt does not advance; the burst completes only after 4 cycles with ready high.
- Early drop and wrap: owner 3 drops req mid-burst with req[0] high -> valid drops that cycle, then a 1-cycle IDLE, then gnt = 4'b0001 (ptr wraps 3 -> 0).
- Reset mid-burst: assert rst while owner 2 has cnt = 2 -> the next edge gives gnt = 0 and cnt = 0; with req = 4'b0101 after reset, requester 0 is granted first.
